// File: rtl/risc_pkg.sv
// Shared types for the RISC instruction-cycle controller: opcodes, states,
// the strobe bundle and the per-state output decoder.
package risc_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int ADDR_W  = 13;

  typedef enum logic [OPC_MSB-OPC_LSB:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_e;

  typedef struct packed {
    logic load_ir;
    logic ir_phase;
    logic inc_pc;
    logic load_pc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic load_acc;
    logic halt;
  } strobes_t;

  function automatic logic is_alu(opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

  // Strobes to present while the FSM sits in state s.
  function automatic strobes_t decode(state_e s, opcode_e op, logic zero);
    strobes_t o;
    o = '0;
    case (s)
      S0: begin
        o.rd      = 1'b1;
        o.load_ir = 1'b1;
        o.inc_pc  = 1'b1;
      end
      S1: begin
        o.rd       = 1'b1;
        o.load_ir  = 1'b1;
        o.ir_phase = 1'b1;
        o.inc_pc   = 1'b1;
      end
      S3: o.halt = (op == HLT);
      S4: begin
        o.rd          = is_alu(op);
        o.datactl_ena = (op == STO);
        o.load_pc     = (op == JMP);
        o.inc_pc      = (op == SKZ) && zero;
      end
      S5: begin
        o.rd          = is_alu(op);
        o.load_acc    = is_alu(op);
        o.wr          = (op == STO);
        o.datactl_ena = (op == STO);
        o.load_pc     = (op == JMP);
        o.inc_pc      = (op == SKZ) && zero;
      end
      S6: o.datactl_ena = (op == STO);
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// Control bundle between the instruction-cycle FSM (master) and the datapath /
// memory stage it steers (slave).
interface risc_ctrl_fsm_if #(
  parameter int OPC_W = 3,
  parameter int CNT_W = 16
);
  logic             ena;
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             load_ir;
  logic             ir_phase;
  logic             inc_pc;
  logic             load_pc;
  logic             rd;
  logic             wr;
  logic             datactl_ena;
  logic             load_acc;
  logic             halt;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  ena, opcode, zero,
    output load_ir, ir_phase, inc_pc, load_pc, rd, wr, datactl_ena,
           load_acc, halt, state, instr_cnt
  );

  modport slave (
    output ena, opcode, zero,
    input  load_ir, ir_phase, inc_pc, load_pc, rd, wr, datactl_ena,
           load_acc, halt, state, instr_cnt
  );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// Eight-state instruction-cycle controller. State, strobes and the retired
// instruction counter all come straight from flops.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int OPC_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  risc_ctrl_fsm_if.master  bus
);

  state_e           state_q;
  state_e           state_n;
  strobes_t         out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;   // 0 = idle after reset/ena drop; next edge enters S0
  logic             zero_q;
  logic             zero_s;
  logic [OPC_W-1:0] opc_raw;
  opcode_e          op;

  assign opc_raw = bus.opcode;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    op      = opcode_e'(opc_raw);
    state_n = S0;
    if (run_q) begin
      case (state_q)
        S3:      state_n = (op == HLT) ? S3 : S4;
        S7:      state_n = S0;
        default: state_n = state_e'(state_q + 3'd1);
      endcase
    end
    // zero is captured on the edge into S4 and held for S5.
    zero_s = (state_n == S4) ? bus.zero : zero_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every flop here is reset, so no strobe survives an asynchronous reset.
      state_q <= S0;
      run_q   <= 1'b0;
      zero_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else if (!bus.ena) begin
      state_q <= S0;
      run_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_n;
      zero_q  <= zero_s;
      out_q   <= decode(state_n, op, zero_s);
      if (run_q && (state_q == S7) && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.load_ir     = out_q.load_ir;
  assign bus.ir_phase    = out_q.ir_phase;
  assign bus.inc_pc      = out_q.inc_pc;
  assign bus.load_pc     = out_q.load_pc;
  assign bus.rd          = out_q.rd;
  assign bus.wr          = out_q.wr;
  assign bus.datactl_ena = out_q.datactl_ena;
  assign bus.load_acc    = out_q.load_acc;
  assign bus.halt        = out_q.halt;
  assign bus.state       = state_q;
  assign bus.instr_cnt   = cnt_q;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed bench for risc_ctrl_fsm: per-instruction strobe tables, HLT hold,
// asynchronous reset mid-store and counter saturation on a 2-bit instance.
module tb_risc_ctrl_fsm;
  import risc_pkg::*;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  risc_ctrl_fsm_if #(.OPC_W(3), .CNT_W(16)) bus ();
  risc_ctrl_fsm_if #(.OPC_W(3), .CNT_W(2))  bus2 ();

  risc_ctrl_fsm #(.OPC_W(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  risc_ctrl_fsm #(.OPC_W(3), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  assign bus2.ena    = bus.ena;
  assign bus2.opcode = bus.opcode;
  assign bus2.zero   = bus.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {load_ir, ir_phase, inc_pc, load_pc, rd, wr, datactl_ena, load_acc, halt}
  function automatic logic [8:0] strobes();
    return {bus.load_ir, bus.ir_phase, bus.inc_pc, bus.load_pc, bus.rd, bus.wr,
            bus.datactl_ena, bus.load_acc, bus.halt};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("inv_rd_wr", 32'(bus.rd & bus.wr), 32'd0);
      check("inv_pc", 32'(bus.load_pc & bus.inc_pc), 32'd0);
      check("inv_wr_dce", 32'(bus.wr & ~bus.datactl_ena), 32'd0);
    end
  end

  typedef struct packed {
    opcode_e    op;
    logic       zero;
    logic       flip;   // invert zero during S4; must not affect S5
    logic [7:0] rd_m;   // bit i = strobe high in state Si
    logic [7:0] wr_m;
    logic [7:0] inc_m;
    logic [7:0] ldpc_m;
    logic [7:0] dce_m;
    logic [7:0] lacc_m;
  } vec_t;

  vec_t vec [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    automatic logic [7:0] ldir_m = 8'h03;
    automatic logic [7:0] irp_m  = 8'h02;
    automatic logic [8:0] exp_s;

    vec[0] = '{LDA, 1'b0, 1'b0, 8'h33, 8'h00, 8'h03, 8'h00, 8'h00, 8'h20};
    vec[1] = '{STO, 1'b0, 1'b0, 8'h03, 8'h20, 8'h03, 8'h00, 8'h70, 8'h00};
    vec[2] = '{SKZ, 1'b1, 1'b1, 8'h03, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00};
    vec[3] = '{SKZ, 1'b0, 1'b1, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    vec[4] = '{JMP, 1'b0, 1'b0, 8'h03, 8'h00, 8'h03, 8'h30, 8'h00, 8'h00};
    vec[5] = '{ADD, 1'b1, 1'b0, 8'h33, 8'h00, 8'h03, 8'h00, 8'h00, 8'h20};
    vec[6] = '{AND, 1'b0, 1'b0, 8'h33, 8'h00, 8'h03, 8'h00, 8'h00, 8'h20};
    vec[7] = '{XOR, 1'b1, 1'b0, 8'h33, 8'h00, 8'h03, 8'h00, 8'h00, 8'h20};

    rst        = 1'b1;
    bus.ena    = 1'b0;
    bus.opcode = LDA;
    bus.zero   = 1'b0;
    #1 rst = 1'b0;
    #10;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_cnt", 32'(bus.instr_cnt), 32'd0);
    #2 rst = 1'b1;
    bus.ena = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.opcode = vec[i].op;
      bus.zero   = vec[i].zero;
      for (int s = 0; s < 8; s++) begin
        tick();
        if (s == 0) check("instr_cnt", 32'(bus.instr_cnt), 32'(i));
        check($sformatf("state i%0d", i), 32'(bus.state), 32'(s));
        exp_s = {ldir_m[s], irp_m[s], vec[i].inc_m[s], vec[i].ldpc_m[s], vec[i].rd_m[s],
                 vec[i].wr_m[s], vec[i].dce_m[s], vec[i].lacc_m[s], 1'b0};
        check($sformatf("strobes i%0d s%0d", i, s), 32'(strobes()), 32'(exp_s));
        if (s == 4 && vec[i].flip) bus.zero = ~bus.zero;
      end
    end

    // HLT: sticks in S3 with halt high until ena drops.
    bus.opcode = HLT;
    for (int s = 0; s < 3; s++) begin
      tick();
      if (s == 0) check("cnt_before_hlt", 32'(bus.instr_cnt), 32'd8);
      check("hlt_state_pre", 32'(bus.state), 32'(s));
    end
    for (int k = 0; k < 21; k++) begin
      tick();
      check("hlt_state", 32'(bus.state), 32'd3);
      check("hlt_strobes", 32'(strobes()), 32'h001);
      check("hlt_cnt", 32'(bus.instr_cnt), 32'd8);
    end
    bus.ena = 1'b0;
    tick();
    check("ena_off_state", 32'(bus.state), 32'd0);
    check("ena_off_strobes", 32'(strobes()), 32'd0);
    tick();
    check("idle_strobes", 32'(strobes()), 32'd0);

    // STO then asynchronous reset in the middle of S5.
    bus.opcode = STO;
    bus.ena    = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick();
      check("sto_state", 32'(bus.state), 32'(s));
    end
    check("sto_s5_wr", 32'(bus.wr), 32'd1);
    check("sto_s5_dce", 32'(bus.datactl_ena), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_wr", 32'(bus.wr), 32'd0);
    check("async_dce", 32'(bus.datactl_ena), 32'd0);
    check("async_state", 32'(bus.state), 32'd0);
    check("async_cnt", 32'(bus.instr_cnt), 32'd0);
    check("async_cnt_small", 32'(bus2.instr_cnt), 32'd0);
    #2 rst = 1'b1;

    // Five instructions: 16-bit counter reaches 5, 2-bit counter saturates at 3.
    bus.opcode = LDA;
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 8; s++) begin
        tick();
        check("sat_state", 32'(bus.state), 32'(s));
      end
    end
    tick();
    check("sat_state_end", 32'(bus.state), 32'd0);
    check("cnt_five", 32'(bus.instr_cnt), 32'd5);
    check("cnt_small_sat", 32'(bus2.instr_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risc_ctrl_fsm.md
Name: risc_ctrl_fsm

Overview:
- Instruction-cycle controller for the 8-bit RISC core.
- Sequences every instruction through eight fixed states.
- Drives the strobes that the address path, ROM/RAM and address decoder consume: rd, wr, PC select/increment, IR load, accumulator load, data-bus enable and halt.
- Sits directly upstream of the memory/address-decode stage. Its rd/wr are the top-level rd/wr, and its halt is the top-level halt.

Parameters:
- OPC_W, 3: opcode width, taken from IR bits [15:13].
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- ena  in  1  run enable; 0 holds the FSM in S0 with all strobes low
- opcode  in  OPC_W  current IR opcode; stable from the cycle after S0 until the next S0
- zero  in  1  accumulator == 0 flag
- load_ir  out  1  IR byte load strobe
- ir_phase  out  1  0 = high byte, 1 = low byte (meaningful only with load_ir)
- inc_pc  out  1  PC += 1
- load_pc  out  1  PC <= IR[12:0]
- rd  out  1  memory read
- wr  out  1  memory write
- datactl_ena  out  1  drive accumulator onto data bus
- load_acc  out  1  accumulator capture
- halt  out  1  core halted
- state  out  3  current state, debug
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALU class = ADD/AND/XOR/LDA.
- Reset (rst=0, asynchronous): state=S0, every output 0, instr_cnt=0. Applies immediately even mid-instruction; no partial strobes survive.
- All outputs are registered (driven from flops). "State Sn outputs" below means the values present during the cycle when state==Sn.
- ena=0 at a clock edge: next state is S0 and next outputs are all 0. Raising ena starts at S0 on the next edge.
- S0: rd=1, load_ir=1, ir_phase=0, inc_pc=1. Next S1.
- S1: rd=1, load_ir=1, ir_phase=1, inc_pc=1. Next S2.
- S2: all strobes 0 (decode). Next S3.
- S3:
  - opcode=HLT: halt=1 and the FSM stays in S3 until reset or ena=0. instr_cnt does not increment.
  - Otherwise: all 0. Next S4.
- S4:
  - ALU: rd=1.
  - STO: datactl_ena=1.
  - JMP: load_pc=1.
  - SKZ with zero=1: inc_pc=1.
  - Else: 0.
  - Next S5.
- S5:
  - ALU: rd=1, load_acc=1.
  - STO: wr=1, datactl_ena=1.
  - JMP: load_pc=1.
  - SKZ with zero=1: inc_pc=1. This second increment completes the 2-byte skip.
  - Next S6.
- S6:
  - STO: datactl_ena=1 (hold data after wr falls).
  - Else: 0.
  - Next S7.
- S7: all 0. instr_cnt increments on the S7->S0 edge, saturating at all-ones. Next S0.
- Sampling rule: zero is sampled at the edge that produces the S4 outputs, and that value is reused for S5. A zero change during S4 has no effect.
- Invariants:
  - rd and wr are never 1 together.
  - load_pc and inc_pc are never 1 together.
  - wr=1 only while datactl_ena=1.
- Instruction latency: exactly 8 cycles per non-HLT instruction.

Decomposition:
- Package risc_pkg holds:
  - opcode enum (OPC_W bits): HLT..JMP
  - state enum: S0..S7, 3 bits
  - instruction field constants: OPC_MSB=15, OPC_LSB=13, ADDR_W=13
- No sub-module. One state register plus a registered output decoder within this block.

Test Plan:
- Reset then ena=1, opcode=LDA(5): state sequence S0..S7 over 8 cycles. rd=1 in S0,S1,S4,S5; load_acc=1 only in S5; instr_cnt=1 after S7.
- opcode=STO(6): wr=1 only in S5; datactl_ena=1 in S4,S5,S6; rd=0 in S4-S7.
- opcode=SKZ(1) with zero=1: inc_pc=1 in S0,S1,S4,S5 (4 pulses). Repeat with zero=0: inc_pc=1 only in S0,S1.
- opcode=JMP(7): load_pc=1 in S4,S5; inc_pc=0 in S4-S7.
- opcode=HLT(0): halt=1 from S3, state stuck at 3 for 20 cycles, instr_cnt unchanged. Drop ena: next cycle state=0, halt=0.
- Assert rst=0 asynchronously mid-S5 of STO: wr and datactl_ena fall without waiting for a clock edge, state=0, instr_cnt=0. With CNT_W=2, run 5 instructions: instr_cnt saturates at 3.
